branch_resolver: RTL

- Execute-side consumer of the ALU's O|S|Z|C flags register.
- Takes branch-class ops (op 12 conditional branch; op 13/14 branch-and-link), evaluates the condition against the current flags, and computes the target.
- Drives a registered redirect to fetch and a multi-cycle flush of wrong-path stages.
- Keeps 32-bit performance counters of resolved and taken branches.

---
 rtl/branch_resolver_if.sv | 30 +++
 rtl/branch_resolver.sv | 103 ++++++++++
 2 files changed

// File: rtl/branch_resolver_if.sv
// Branch-resolver bundle: execute-side branch slot in, redirect/flush/link and
// perf counters out. The issuing stage is the master.
interface branch_resolver_if;
   logic        bubble;
   logic [4:0]  op;
   logic [3:0]  cond;
   logic [3:0]  flags;
   logic [31:0] pc;
   logic [31:0] imm;
   logic [31:0] reg_target;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        link_we;
   logic [31:0] link_value;
   logic        busy;
   logic [31:0] branch_count;
   logic [31:0] taken_count;

   modport master (
      output bubble, op, cond, flags, pc, imm, reg_target,
      input  redirect, redirect_pc, flush, link_we, link_value, busy,
             branch_count, taken_count
   );
   modport slave (
      input  bubble, op, cond, flags, pc, imm, reg_target,
      output redirect, redirect_pc, flush, link_we, link_value, busy,
             branch_count, taken_count
   );
endinterface

// File: rtl/branch_resolver.sv
// Resolves br/bl/blr against the O|S|Z|C flags, issues a registered redirect
// and a FLUSH_DEPTH-cycle squash, and counts resolved/taken branches.
module branch_resolver #(
   parameter int unsigned FLUSH_DEPTH = 2
) (
   input logic             clk,
   input logic             rst_n,
   branch_resolver_if.slave bus
);
   if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > 15) begin : g_bad_depth
      $error("branch_resolver: FLUSH_DEPTH must be 1..15");
   end

   typedef enum logic [1:0] {IDLE, REDIR, SQUASH} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        link_pend;
   logic [31:0] target_q, link_q, br_cnt, tk_cnt;
   logic        o, s, z, c;
   logic        cond_ok, is_branch, accept, taken;
   logic [31:0] rel_sum, target;

   assign {o, s, z, c} = bus.flags;

   always_comb begin
      cond_ok = 1'b0;
      case (bus.cond)
         4'd0:  cond_ok = 1'b1;
         4'd1:  cond_ok = z;
         4'd2:  cond_ok = !z;
         4'd3:  cond_ok = c;
         4'd4:  cond_ok = !c;
         4'd5:  cond_ok = s;
         4'd6:  cond_ok = !s;
         4'd7:  cond_ok = o;
         4'd8:  cond_ok = !o;
         4'd9:  cond_ok = !z && (s == o);
         4'd10: cond_ok = (s == o);
         4'd11: cond_ok = (s != o);
         4'd12: cond_ok = z || (s != o);
         4'd13: cond_ok = c && !z;
         4'd14: cond_ok = !c || z;
         default: cond_ok = 1'b0;
      endcase
   end

   // Wrong-path slots during REDIR/SQUASH are never accepted.
   assign is_branch = (bus.op == 5'd12) || (bus.op == 5'd13) || (bus.op == 5'd14);
   assign accept    = (state == IDLE) && !bus.bubble && is_branch;
   assign taken     = accept && ((bus.op != 5'd12) || cond_ok);
   assign rel_sum   = bus.pc + bus.imm;
   assign target    = (bus.op == 5'd14) ? {bus.reg_target[31:2], 2'b00}
                                        : {rel_sum[31:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (taken) state_nxt = REDIR;
         REDIR:   state_nxt = (FLUSH_DEPTH == 1) ? IDLE : SQUASH;
         SQUASH:  if (cnt == 4'd1) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         link_pend <= 1'b0;
         target_q  <= '0;
         link_q    <= '0;
         br_cnt    <= '0;
         tk_cnt    <= '0;
      end else begin
         if (state == REDIR)  cnt <= 4'(FLUSH_DEPTH - 1);
         if (state == SQUASH) cnt <= cnt - 4'd1;
         if (accept) br_cnt <= br_cnt + 32'd1;
         if (taken) begin
            tk_cnt    <= tk_cnt + 32'd1;
            target_q  <= target;
            link_pend <= (bus.op != 5'd12);
            if (bus.op != 5'd12) link_q <= bus.pc + 32'd4;
         end
      end
   end

   always_comb begin
      bus.redirect = (state == REDIR);
      bus.link_we  = (state == REDIR) && link_pend;
      bus.flush    = (state != IDLE);
      bus.busy     = (state != IDLE);
   end

   assign bus.redirect_pc  = target_q;
   assign bus.link_value   = link_q;
   assign bus.branch_count = br_cnt;
   assign bus.taken_count  = tk_cnt;
endmodule
